// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, in-flight queue
// entry layout and saturating counter helpers.
package bp_pkg;

    localparam int BP_BHT_ENTRIES = 64;
    localparam int BP_IDX_W       = $clog2(BP_BHT_ENTRIES);

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_t;

    // Queue entries carry the exact index that predicted, so training lands on
    // the same counter even when the index is history-hashed.
    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                pred;
    } bp_q_entry_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == ST) ? ST : cnt_t'(c + 2'd1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t c);
        return (c == SNT) ? SNT : cnt_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// In-order in-flight branch queue. Flush discards everything younger than the
// entry popped in the same cycle; a same-cycle push is dropped on flush.
module bp_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  bp_q_entry_t data_i,
    output logic        full_o,
    output logic        empty_o,
    output bp_q_entry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    bp_q_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & ~full_o & ~flush_i;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        rd_d  = rd_q + PTR_W'(pop_ok);
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = rd_d;
            cnt_d = '0;
        end else begin
            wr_d = wr_q + PTR_W'(push_ok);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; an entry is only visible
    // once the count covers it, and consumers gate head data with empty_o.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bht_predictor.sv
// 2-bit-counter branch direction predictor with an in-order training queue.
// Optional BHT_GSHARE_EN hashes the index with a non-speculative global history.
module bht_predictor
    import bp_pkg::*;
#(
    parameter int   PC_WIDTH    = 32,
    parameter int   BHT_ENTRIES = BP_BHT_ENTRIES,
    parameter int   Q_DEPTH     = 4,
    parameter cnt_t CNT_INIT    = WNT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PC_WIDTH-1:0] F_PC_i,
    input  logic                F_branch_i,
    input  logic                F_train_valid_i,
    output logic                F_pred_taken_o,
    output logic                F_stall_o,
    input  logic                E_resolve_valid_i,
    input  logic                E_taken_i,
    input  logic                E_flush_i,
    output logic                E_head_valid_o,
    output logic                E_head_pred_o,
    output logic                E_underflow_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    cnt_t             cnt_q [BHT_ENTRIES];
    cnt_t             cnt_upd;
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] train_idx;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    bp_q_entry_t      push_entry;
    bp_q_entry_t      head_entry;
    logic             underflow_q, underflow_d;
    logic             unused_pc_bits;

    assign pc_idx         = F_PC_i[IDX_W+1:2];
    assign unused_pc_bits = ^{F_PC_i[PC_WIDTH-1:IDX_W+2], F_PC_i[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign f_idx = pc_idx ^ ghr_q;
    assign ghr_d = pop ? {ghr_q[IDX_W-2:0], E_taken_i} : ghr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign f_idx = pc_idx;
`endif

    // Fetch reads the registered counter; a same-edge update is not bypassed.
    assign F_pred_taken_o = F_branch_i & (cnt_q[f_idx] inside {WT, ST});

    assign push            = F_train_valid_i & ~F_stall_o & ~E_flush_i;
    assign pop             = E_resolve_valid_i & E_head_valid_o;
    assign push_entry.idx  = BP_IDX_W'(f_idx);
    assign push_entry.pred = F_pred_taken_o;

    bp_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (E_flush_i),
        .data_i  (push_entry),
        .full_o  (F_stall_o),
        .empty_o (fifo_empty),
        .head_o  (head_entry)
    );

    assign E_head_valid_o = ~fifo_empty;
    assign E_head_pred_o  = E_head_valid_o & head_entry.pred;
    assign train_idx      = IDX_W'(head_entry.idx);

    assign cnt_upd     = E_taken_i ? sat_inc(cnt_q[train_idx]) : sat_dec(cnt_q[train_idx]);
    assign underflow_d = underflow_q | (E_resolve_valid_i & fifo_empty);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (pop) begin
            cnt_q[train_idx] <= cnt_upd;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign E_underflow_o = underflow_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor (default 64 counters, depth-4 queue).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_bht_predictor;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] F_PC_i;
    logic        F_branch_i;
    logic        F_train_valid_i;
    logic        F_pred_taken_o;
    logic        F_stall_o;
    logic        E_resolve_valid_i;
    logic        E_taken_i;
    logic        E_flush_i;
    logic        E_head_valid_o;
    logic        E_head_pred_o;
    logic        E_underflow_o;

    int checks = 0;
    int errors = 0;

    bht_predictor u_dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .F_PC_i            (F_PC_i),
        .F_branch_i        (F_branch_i),
        .F_train_valid_i   (F_train_valid_i),
        .F_pred_taken_o    (F_pred_taken_o),
        .F_stall_o         (F_stall_o),
        .E_resolve_valid_i (E_resolve_valid_i),
        .E_taken_i         (E_taken_i),
        .E_flush_i         (E_flush_i),
        .E_head_valid_o    (E_head_valid_o),
        .E_head_pred_o     (E_head_pred_o),
        .E_underflow_o     (E_underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        F_train_valid_i   = 1'b0;
        E_resolve_valid_i = 1'b0;
        E_taken_i         = 1'b0;
        E_flush_i         = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        F_PC_i     = 32'h100;
        F_branch_i = 1'b1;
        idle();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;

        // 1: reset state and first query (idx 0 holds WNT)
        check("rst_pred",      F_pred_taken_o, 0);
        check("rst_stall",     F_stall_o, 0);
        check("rst_head_vld",  E_head_valid_o, 0);
        check("rst_head_pred", E_head_pred_o, 0);
        check("rst_underflow", E_underflow_o, 0);
        check("rst_cnt0",      u_dut.cnt_q[0], 1);

        // 2: train idx 0 taken until saturated
        F_train_valid_i = 1'b1;
        tick();
        F_train_valid_i = 1'b0;
        check("t2_head_vld",  E_head_valid_o, 1);
        check("t2_head_pred", E_head_pred_o, 0);
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        tick();
        idle(); #1;
        check("t2_cnt_wt",    u_dut.cnt_q[0], 2);
        check("t2_empty",     E_head_valid_o, 0);
        check("t2_pred1",     F_pred_taken_o, 1);
        F_train_valid_i = 1'b1;
        tick();
        idle();
        check("t2_head_pred1", E_head_pred_o, 1);
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        tick();
        check("t2_cnt_st",    u_dut.cnt_q[0], 3);
        // push and pop together: count holds, counter stays saturated
        F_train_valid_i = 1'b1;
        E_resolve_valid_i = 1'b0;
        tick();
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        tick();
        F_train_valid_i = 1'b0;
        check("t2_pushpop_vld", E_head_valid_o, 1);
        check("t2_sat_once",    u_dut.cnt_q[0], 3);
        tick();
        idle(); #1;
        check("t2_sat_twice",   u_dut.cnt_q[0], 3);
        check("t2_drained",     E_head_valid_o, 0);

        // 3: fill the queue (idx 1..4), then a 5th push is refused
        F_train_valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            F_PC_i = 32'h100 + 32'(4 * i);
            tick();
        end
        check("t3_stall",     F_stall_o, 1);
        F_PC_i = 32'h114;
        tick();
        F_train_valid_i = 1'b0;
        check("t3_stall_hold", F_stall_o, 1);
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        #1;
        check("t3_stall_same_cycle", F_stall_o, 1);
        tick();
        idle(); #1;
        check("t3_stall_clear", F_stall_o, 0);
        check("t3_cnt1",        u_dut.cnt_q[1], 2);
        check("t3_cnt5_untouched", u_dut.cnt_q[5], 1);

        // 4: three entries (idx 2,3,4); resolve not-taken with flush and a push
        F_PC_i = 32'h100;
        F_train_valid_i   = 1'b1;
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b0; E_flush_i = 1'b1;
        tick();
        idle(); #1;
        check("t4_cnt2",     u_dut.cnt_q[2], 0);
        check("t4_cnt3",     u_dut.cnt_q[3], 1);
        check("t4_empty",    E_head_valid_o, 0);
        check("t4_stall",    F_stall_o, 0);
        check("t4_cnt0",     u_dut.cnt_q[0], 3);
        F_PC_i = 32'h200;   // also idx 0
        F_train_valid_i = 1'b1;
        tick();
        F_train_valid_i = 1'b0;
        check("t4_post_vld",  E_head_valid_o, 1);
        check("t4_post_pred", E_head_pred_o, 1);
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b0;
        tick();
        idle(); #1;
        check("t4_dec_cnt0",  u_dut.cnt_q[0], 2);
        check("t4_post_empty", E_head_valid_o, 0);

        // 5: resolve on an empty queue with a same-cycle push
        F_PC_i = 32'h100;
        F_train_valid_i   = 1'b1;
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        tick();
        idle(); #1;
        check("t5_underflow",  E_underflow_o, 1);
        check("t5_cnt0_same",  u_dut.cnt_q[0], 2);
        check("t5_push_kept",  E_head_valid_o, 1);
        tick();
        tick();
        check("t5_sticky",     E_underflow_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("t5_arst_underflow", E_underflow_o, 0);
        check("t5_arst_head_vld",  E_head_valid_o, 0);
        check("t5_arst_cnt0",      u_dut.cnt_q[0], 1);
        check("t5_arst_cnt1",      u_dut.cnt_q[1], 1);
        tick();
        rst_i = 1'b0;
        #1;

`ifdef BHT_GSHARE_EN
        // 6: history-hashed index; training follows the stored idx
        F_PC_i = 32'h100;
        F_train_valid_i = 1'b1;
        tick();
        F_train_valid_i = 1'b0;
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        tick();
        idle(); #1;
        check("t6_cnt0",   u_dut.cnt_q[0], 2);
        check("t6_ghr1",   u_dut.ghr_q, 1);
        check("t6_pred_idx1", F_pred_taken_o, 0);
        F_train_valid_i = 1'b1;
        tick();
        F_train_valid_i = 1'b0;
        E_resolve_valid_i = 1'b1; E_taken_i = 1'b1;
        tick();
        idle(); #1;
        check("t6_cnt1",   u_dut.cnt_q[1], 2);
        check("t6_cnt0_kept", u_dut.cnt_q[0], 2);
        check("t6_ghr3",   u_dut.ghr_q, 3);
        check("t6_pred_idx3", F_pred_taken_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
